sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO. It is the next generation of the team's dual-clock FIFO model, for designs where producer and consumer share one clock. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, sticky overflow/underflow error flags and a synchronous flush. It sits between a producer and a consumer as the standard buffering primitive.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/sync_fifo_flags_if.sv | 34 +++
 rtl/fifo_ram.sv | 30 +++
 rtl/sync_fifo_flags.sv | 132 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock flagged FIFO family.
// Contents:
//   read_mode_e  - read-port behaviour (registered vs first-word-fall-through)
//   ptr_w/cnt_w  - pointer and occupancy widths derived from the depth
//   params_ok    - parameter legality predicate, evaluated at elaboration
package fifo_pkg;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that "full" (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int afull, input int aempty,
                                     input int fwft);
        return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (afull >= 1) && (afull <= depth) &&
               (aempty >= 0) && (aempty <= depth - 1) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags.
// master: the side driving requests (din/wen/ren/flush/clr_err) and observing status.
// slave : the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = fifo_pkg::cnt_w(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] din;
    logic                  wen;
    logic                  ren;
    logic                  flush;
    logic                  clr_err;
    logic [FIFO_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output din, wen, ren, flush, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  din, wen, ren, flush, clr_err,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: WIDTH x DEPTH words.
// Ports:
//   clk            - write clock
//   we/waddr/wdata - synchronous write port
//   raddr/rdata    - asynchronous (combinational) read port
// Contents are deliberately not reset.
module fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and selectable read mode.
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset (pointers, count, dout, error flags)
//   fif    - slave side of sync_fifo_flags_if:
//            din/wen write, ren pop, flush empty, clr_err clear errors,
//            dout read data, full/empty/almost_* status, count, overflow/underflow
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_TH   = FIFO_DEPTH - 1,
    parameter int AEMPTY_TH  = 1,
    parameter int FWFT       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_flags_if.slave   fif
);

    localparam int         PTR_W = ptr_w(FIFO_DEPTH);
    localparam int         CNT_W = cnt_w(FIFO_DEPTH);
    localparam read_mode_e MODE  = (FWFT != 0) ? READ_FWFT : READ_STD;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    if (!params_ok(FIFO_WIDTH, FIFO_DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_param_err
        $error("sync_fifo_flags: illegal parameters (depth must be a power of two >= 2, thresholds in range)");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  empty, full;
    logic                  rd_acc, wr_acc, mem_we;
    logic [FIFO_WIDTH-1:0] rd_data;

    fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (fif.din),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Flags come from the count register alone, so they move on the same edge as count.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A full FIFO still takes a write when a pop frees a slot in the same cycle.
    assign rd_acc = fif.ren & ~empty;
    assign wr_acc = fif.wen & (~full | rd_acc);
    assign mem_we = wr_acc & ~fif.flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (fif.flush) begin
            // Flush overrides every request; dout and error flags are left alone.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (MODE == READ_STD) begin
                    dout_d = rd_data;
                end
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, wr_acc} - {{(CNT_W-1){1'b0}}, rd_acc};

            // Set beats clear when both happen in one cycle.
            overflow_d  = (fif.wen & full & ~rd_acc) | (overflow_q  & ~fif.clr_err);
            underflow_d = (fif.ren & empty)          | (underflow_q & ~fif.clr_err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (MODE == READ_FWFT) begin : g_fwft
        // Head word is presented directly; forced to zero while nothing is stored.
        assign fif.dout = empty ? '0 : rd_data;
    end else begin : g_std
        assign fif.dout = dout_q;
    end

    assign fif.full         = full;
    assign fif.empty        = empty;
    assign fif.almost_full  = (count_q >= AFULL_C);
    assign fif.almost_empty = (count_q <= AEMPTY_C);
    assign fif.count        = count_q;
    assign fif.overflow     = overflow_q;
    assign fif.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
    localparam int W     = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;

    typedef struct {
        int         cnt;
        bit         ov;
        bit         uf;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) if_s ();
    sync_fifo_flags_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) if_f ();

    sync_fifo_flags #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0))
        u_std (.clk(clk), .rst_n(rst_n), .fif(if_s));
    sync_fifo_flags #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .fif(if_f));

    // Reference model: stored words as a queue, plus the registered read word.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_d0;
    bit           m_ov, m_uf;
    exp_t         exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        bit e_full, e_empty, e_af, e_ae;
        e_full  = (e.cnt == DEPTH);
        e_empty = (e.cnt == 0);
        e_af    = (e.cnt >= AF);
        e_ae    = (e.cnt <= AE);
        chk("count",        32'(if_s.count),        32'(e.cnt));
        chk("count_fwft",   32'(if_f.count),        32'(e.cnt));
        chk("full",         32'(if_s.full),         32'(e_full));
        chk("empty",        32'(if_s.empty),        32'(e_empty));
        chk("almost_full",  32'(if_s.almost_full),  32'(e_af));
        chk("almost_empty", 32'(if_s.almost_empty), 32'(e_ae));
        chk("empty_fwft",   32'(if_f.empty),        32'(e_empty));
        chk("overflow",     32'(if_s.overflow),     32'(e.ov));
        chk("underflow",    32'(if_s.underflow),    32'(e.uf));
        chk("overflow_fwft",  32'(if_f.overflow),   32'(e.ov));
        chk("underflow_fwft", 32'(if_f.underflow),  32'(e.uf));
        chk("dout_std",     32'(if_s.dout),         32'(e.d0));
        chk("dout_fwft",    32'(if_f.dout),         32'(e.d1));
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.cnt = m_q.size();
        e.ov  = m_ov;
        e.uf  = m_uf;
        e.d0  = m_d0;
        e.d1  = (m_q.size() != 0) ? m_q[0] : '0;
        return e;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_d0 = '0;
        m_ov = 1'b0;
        m_uf = 1'b0;
    endfunction

    task automatic drive(input bit w, input bit r, input bit f, input bit c, input logic [W-1:0] d);
        if_s.wen = w; if_s.ren = r; if_s.flush = f; if_s.clr_err = c; if_s.din = d;
        if_f.wen = w; if_f.ren = r; if_f.flush = f; if_f.clr_err = c; if_f.din = d;
    endtask

    // Called just after a rising edge; applies inputs for the next edge and
    // queues the state expected after it.
    task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [W-1:0] d);
        bit emp, ful, rd, wr, ovs, ufs;
        drive(w, r, f, c, d);
        if (f) begin
            m_q.delete();
        end else begin
            emp = (m_q.size() == 0);
            ful = (m_q.size() == DEPTH);
            rd  = r && !emp;
            wr  = w && (!ful || rd);
            ovs = w && ful && !rd;
            ufs = r && emp;
            if (rd) m_d0 = m_q.pop_front();
            if (wr) m_q.push_back(d);
            m_ov = ovs || (m_ov && !c);
            m_uf = ufs || (m_uf && !c);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(model_snapshot());
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: status and data are valid every cycle, so one check per edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   pw, pr;
        drive(0, 0, 0, 0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all(model_snapshot());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 12 writes into an 8-deep FIFO
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, W'(i + 1));
        // 2: 12 reads, last four underflow
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);
        // 3: full FIFO, simultaneous write and read
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, W'(i + 2));
        step(1, 1, 0, 0, 3'd5);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        // 4: empty FIFO, simultaneous write and read
        step(0, 0, 0, 1, '0);
        step(1, 1, 0, 0, 3'd6);
        step(0, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);
        // 5: flush beats a write; pointers restart
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, W'(i + 4));
        step(1, 0, 1, 0, 3'd7);
        step(1, 0, 0, 0, 3'd3);
        step(0, 1, 0, 0, '0);
        step(0, 1, 1, 0, '0);
        // 6: overflow then clear; set-wins-over-clear
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, W'(i));
        step(1, 0, 0, 1, 3'd1);
        step(0, 0, 0, 1, '0);
        step(0, 0, 1, 0, '0);

        // Randomised traffic, alternating write-heavy and read-heavy phases.
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 80; i++) begin
                bit w, r, f, c;
                w = ($urandom_range(99) < pw);
                r = ($urandom_range(99) < pr);
                f = ($urandom_range(99) < 3);
                c = !f && ($urandom_range(99) < 6);
                step(w, r, f, c, W'($urandom));
            end
        end

        // Asynchronous reset between edges while traffic is pending.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, W'($urandom));
        step(1, 1, 0, 0, 3'd2);
        drain();
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(if_s.count), 32'd0);
        chk("async_rst_empty", 32'(if_s.empty), 32'd1);
        chk("async_rst_dout_std", 32'(if_s.dout), 32'd0);
        chk("async_rst_dout_fwft", 32'(if_f.dout), 32'd0);
        chk("async_rst_count_fwft", 32'(if_f.count), 32'd0);
        model_reset();
        drive(0, 0, 0, 0, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 3'd4);
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
